// File: rtl/gauss_pkg.sv
// gauss_pkg: definitions shared by the Gaussian sampler and the coefficient
// collector. It holds the collector state encoding, the LOGN-derived sample
// width and range limit, and the squared-norm acceptance bound.
package gauss_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN_F,
    RUN_G,
    CHECK,
    DONE
  } gauss_state_t;

  // (f,g) is rejected when its squared norm reaches this bound.
  localparam int unsigned GAUSS_NORM_BOUND = 16823;

  // Width of a signed sample for the given polynomial degree.
  function automatic int unsigned gauss_val_bit(input int unsigned logn);
    return (logn == 9) ? 7 : 6;
  endfunction

  // A coefficient v is legal iff -lim < v < lim.
  function automatic int unsigned gauss_coef_lim(input int unsigned logn);
    return (logn == 9) ? 32 : 16;
  endfunction

endpackage

// File: rtl/gauss_poly_collect_if.sv
// gauss_poly_collect_if: interface bundling the collector's signals.
//   Keygen controller side: start, busy, done, reject, sqnorm.
//   Sampler side: gauss_ena, val_valid, val.
//   RAM side: coef_we, coef_sel, coef_addr, coef_data.
// Modports:
//   master - the environment: drives start/val_valid/val, observes the rest.
//   slave  - the collector itself.
interface gauss_poly_collect_if
  import gauss_pkg::*;
#(
  parameter int unsigned LOGN    = 9,
  parameter int unsigned VAL_BIT = gauss_val_bit(LOGN),
  parameter int unsigned SQ_W    = 24
);
  logic                      start;
  logic                      gauss_ena;
  logic                      val_valid;
  logic signed [VAL_BIT-1:0] val;
  logic                      coef_we;
  logic                      coef_sel;
  logic [LOGN-1:0]           coef_addr;
  logic signed [VAL_BIT-1:0] coef_data;
  logic                      busy;
  logic                      done;
  logic                      reject;
  logic [SQ_W-1:0]           sqnorm;

  modport master (
    output start, val_valid, val,
    input  gauss_ena, coef_we, coef_sel, coef_addr, coef_data,
           busy, done, reject, sqnorm
  );

  modport slave (
    input  start, val_valid, val,
    output gauss_ena, coef_we, coef_sel, coef_addr, coef_data,
           busy, done, reject, sqnorm
  );
endinterface

// File: rtl/gauss_sqacc.sv
// gauss_sqacc: saturating accumulator of squared signed samples.
// Ports:
//   clk, rst - clock, synchronous active-high reset
//   clr      - clears the sum (start of a new run)
//   en       - adds val*val to the sum this cycle
//   val      - signed sample
//   sum      - running sum; sticks at all-ones instead of wrapping
module gauss_sqacc #(
  parameter int unsigned VAL_BIT = 7,
  parameter int unsigned SQ_W    = 24
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      en,
  input  logic signed [VAL_BIT-1:0] val,
  output logic [SQ_W-1:0]           sum
);

  logic signed [2*VAL_BIT-1:0] v_ext;
  logic signed [2*VAL_BIT-1:0] sq_s;
  logic [2*VAL_BIT-1:0]        sq;
  logic [SQ_W:0]               nxt;

  // The square of -2^(VAL_BIT-1) is 2^(2*VAL_BIT-2): it fits the double-width
  // product when read as unsigned.
  always_comb begin
    v_ext = {{VAL_BIT{val[VAL_BIT-1]}}, val};
    sq_s  = v_ext * v_ext;
    sq    = $unsigned(sq_s);
    nxt   = {1'b0, sum} + (SQ_W + 1)'(sq);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sum <= '0;
    end else if (en) begin
      sum <= nxt[SQ_W] ? '1 : nxt[SQ_W-1:0];
    end
  end

endmodule

// File: rtl/gauss_poly_collect.sv
// gauss_poly_collect: enables the Gaussian sampler, collects 2N signed
// coefficients (N for f, then N for g), writes them to the coefficient RAM,
// range-checks each one and accumulates the squared norm of (f,g). At the end
// it pulses done with an accept/reject verdict.
// Ports:
//   clk, rst - clock, synchronous active-high reset
//   bus      - gauss_poly_collect_if.slave: start/busy/done/reject/sqnorm,
//              sampler gauss_ena/val_valid/val, RAM coef_we/sel/addr/data
// Build option: define GAUSS_COLLECT_EARLY_ABORT_EN to stop sampling at the
// first out-of-range coefficient (that coefficient is not written).
module gauss_poly_collect
  import gauss_pkg::*;
#(
  parameter int unsigned LOGN       = 9,
  parameter int unsigned VAL_BIT    = gauss_val_bit(LOGN),
  parameter int unsigned COEF_LIM   = gauss_coef_lim(LOGN),
  parameter int unsigned NORM_BOUND = GAUSS_NORM_BOUND,
  parameter int unsigned SQ_W       = 24
) (
  input logic                 clk,
  input logic                 rst,
  gauss_poly_collect_if.slave bus
);

  gauss_state_t              state;
  logic [LOGN-1:0]           idx;
  logic                      last_q;
  logic                      range_err;
  logic signed [VAL_BIT-1:0] val_s;
  int                        v_int;
  logic                      oor;
  logic                      take;
  logic                      abort;
  logic                      wr_ok;
  logic                      start_ok;
  logic [SQ_W-1:0]           acc_sum;

  always_comb begin
    val_s    = bus.val;
    v_int    = int'(val_s);
    oor      = (v_int >= int'(COEF_LIM)) || (v_int <= -int'(COEF_LIM));
    take     = bus.val_valid && ((state == RUN_F) || (state == RUN_G)) && !last_q;
`ifdef GAUSS_COLLECT_EARLY_ABORT_EN
    abort    = take && oor;
`else
    abort    = 1'b0;
`endif
    wr_ok    = take && !abort;
    start_ok = (state == IDLE) && bus.start;
  end

  gauss_sqacc #(
    .VAL_BIT (VAL_BIT),
    .SQ_W    (SQ_W)
  ) u_sqacc (
    .clk (clk),
    .rst (rst),
    .clr (start_ok),
    .en  (wr_ok),
    .val (val_s),
    .sum (acc_sum)
  );

  assign bus.sqnorm = acc_sum;

  // After the last g sample is accepted, one more RUN_G cycle (last_q set)
  // lets the registered write and the final accumulation land before CHECK
  // reads the sum; samples in that cycle are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      last_q        <= 1'b0;
      range_err     <= 1'b0;
      bus.gauss_ena <= 1'b0;
      bus.coef_we   <= 1'b0;
      bus.coef_sel  <= 1'b0;
      bus.coef_addr <= '0;
      bus.coef_data <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.reject    <= 1'b0;
    end else begin
      bus.coef_we <= 1'b0;
      bus.done    <= 1'b0;
      if (wr_ok) begin
        bus.coef_we   <= 1'b1;
        bus.coef_sel  <= (state == RUN_G);
        bus.coef_addr <= idx;
        bus.coef_data <= val_s;
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            state         <= RUN_F;
            idx           <= '0;
            last_q        <= 1'b0;
            range_err     <= 1'b0;
            bus.reject    <= 1'b0;
            bus.busy      <= 1'b1;
            bus.gauss_ena <= 1'b1;
          end
        end
        RUN_F, RUN_G: begin
          if (last_q) begin
            state         <= CHECK;
            last_q        <= 1'b0;
            bus.gauss_ena <= 1'b0;
          end else if (take) begin
            if (oor) range_err <= 1'b1;
            if (abort) begin
              state         <= CHECK;
              bus.gauss_ena <= 1'b0;
            end else begin
              idx <= idx + 1'b1;
              if (idx == '1) begin
                if (state == RUN_F) state <= RUN_G;
                else last_q <= 1'b1;
              end
            end
          end
        end
        CHECK: begin
          bus.reject <= range_err | (acc_sum >= SQ_W'(NORM_BOUND));
          bus.done   <= 1'b1;
          bus.busy   <= 1'b0;
          state      <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gauss_poly_collect.sv
// tb_gauss_poly_collect: directed bench for gauss_poly_collect (LOGN=9).
// Each run feeds samples from the samp[] table, checks every RAM write as it
// appears, then checks CHECK/DONE timing, sqnorm and reject.
module tb_gauss_poly_collect;

  localparam int N  = 512;
  localparam int VB = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;

  gauss_poly_collect_if #(.LOGN(9), .VAL_BIT(VB), .SQ_W(24)) bus ();

  gauss_poly_collect #(.LOGN(9)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  logic signed [VB-1:0] samp [2*N];
  int n_cmp = 0;
  int n_err = 0;
  int wr_total = 0;
  int wr_base  = 0;

  // Independent write counter, catches writes the stimulus did not ask for.
  always @(negedge clk) begin
    if (bus.coef_we) wr_total <= wr_total + 1;
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < 2*N; i++) samp[i] = VB'(v);
  endtask

  function automatic bit is_oor(input logic signed [VB-1:0] v);
    return (v >= 32) || (v <= -32);
  endfunction

  task automatic check_all_zero(input string tag);
    check(tag, {bus.gauss_ena, bus.coef_we, bus.coef_sel, bus.coef_addr,
                bus.coef_data, bus.busy, bus.done, bus.reject, bus.sqnorm}, 0);
  endtask

  task automatic start_run(input string tag);
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    wr_base = wr_total;
    check({tag, "_busy"}, bus.busy, 1);
    check({tag, "_ena"}, bus.gauss_ena, 1);
    check({tag, "_sq_clr"}, bus.sqnorm, 0);
    check({tag, "_rej_clr"}, bus.reject, 0);
  endtask

  // Feeds samp[0..n-1], one val_valid pulse every other cycle; the write for
  // each sample must be visible right after the edge that sampled it.
  task automatic feed(input string tag, input int n, input bit disturb);
    bit exp_we;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.val_valid = 1'b1;
      bus.val       = samp[i];
      if (disturb && i == N + 10) bus.start = 1'b1;
      @(posedge clk); #1;
      bus.val_valid = 1'b0;
      bus.start     = 1'b0;
`ifdef GAUSS_COLLECT_EARLY_ABORT_EN
      exp_we = !is_oor(samp[i]);
`else
      exp_we = 1'b1;
`endif
      if (exp_we)
        check({tag, "_wr"}, {bus.coef_we, bus.coef_sel, bus.coef_addr, bus.coef_data},
              {1'b1, (i >= N), 9'(i % N), samp[i]});
      else
        check({tag, "_wr_supp"}, bus.coef_we, 0);
    end
  endtask

  // Called right after the last sample's edge. CHECK follows one cycle
  // later and done one cycle after that. A late sample in CHECK is ignored.
  task automatic finish_run(input string tag, input longint exp_sq, input bit exp_rej);
    check({tag, "_ena_reg"}, bus.gauss_ena, 1);
    check({tag, "_done_early"}, bus.done, 0);
    @(posedge clk); #1;
    check({tag, "_ena_chk"}, bus.gauss_ena, 0);
    check({tag, "_done_chk"}, bus.done, 0);
    bus.val_valid = 1'b1;
    bus.val       = 7'sd5;
    @(posedge clk); #1;
    bus.val_valid = 1'b0;
    check({tag, "_done"}, bus.done, 1);
    check({tag, "_sqnorm"}, bus.sqnorm, exp_sq);
    check({tag, "_reject"}, bus.reject, exp_rej);
    check({tag, "_busy_end"}, bus.busy, 0);
    check({tag, "_nwr"}, wr_total - wr_base, 2*N);
  endtask

  int done_seen;

  initial begin
    bus.start     = 1'b0;
    bus.val_valid = 1'b0;
    bus.val       = '0;

    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    rst = 1'b0;

    // val_valid while IDLE: no writes
    wr_base = wr_total;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 bus.val_valid = 1'b1; bus.val = 7'sd9;
      @(posedge clk); #1 bus.val_valid = 1'b0;
    end
    @(posedge clk); #1;
    check("idle_vv_nwr", wr_total - wr_base, 0);
    check("idle_vv_busy", bus.busy, 0);

    fill(0);  start_run("zero"); feed("zero", 2*N, 0); finish_run("zero", 0, 0);
    fill(3);  start_run("p3");   feed("p3", 2*N, 1);   finish_run("p3", 9216, 0);
    fill(4);  start_run("p4");   feed("p4", 2*N, 0);   finish_run("p4", 16384, 0);
    fill(4);  samp[700] = 7'sd5;
    start_run("p4p5"); feed("p4p5", 2*N, 0); finish_run("p4p5", 16393, 0);
    fill(5);  start_run("p5");   feed("p5", 2*N, 0);   finish_run("p5", 25600, 1);

    // start held across the DONE cycle and the following IDLE cycle
    bus.start = 1'b1;
    @(posedge clk); #1;
    check("b2b_done_ignored", bus.busy, 0);
    check("b2b_rej_held", bus.reject, 1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    wr_base = wr_total;
    check("b2b_busy", bus.busy, 1);
    check("b2b_rej_clr", bus.reject, 0);
    check("b2b_sq_clr", bus.sqnorm, 0);
    fill(0); feed("b2b", 2*N, 0); finish_run("b2b", 0, 0);

    // legal extremes of the range
    fill(0); samp[3] = -7'sd31; samp[600] = 7'sd31;
    start_run("lim31"); feed("lim31", 2*N, 0); finish_run("lim31", 1922, 0);

    fill(0); samp[7] = -7'sd32;
    start_run("m32");
`ifdef GAUSS_COLLECT_EARLY_ABORT_EN
    feed("m32", 8, 0);
    check("m32_ena_drop", bus.gauss_ena, 0);
    @(posedge clk); #1;
    check("m32_done", bus.done, 1);
    check("m32_reject", bus.reject, 1);
    check("m32_sqnorm", bus.sqnorm, 0);
    check("m32_nwr", wr_total - wr_base, 7);
`else
    feed("m32", 2*N, 0); finish_run("m32", 1024, 1);

    // most negative sample: square 4096
    fill(0); samp[N] = -7'sd64;
    start_run("m64"); feed("m64", 2*N, 0); finish_run("m64", 4096, 1);
`endif

    // reset at g index 100
    fill(2);
    start_run("rstmid"); feed("rstmid", N + 100, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_all_zero("rstmid_out");
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.done) done_seen++;
    end
    check("rstmid_no_done", done_seen, 0);
    check("rstmid_nwr", wr_total - wr_base, N + 100);

    fill(1); start_run("post_rst"); feed("post_rst", 2*N, 0); finish_run("post_rst", 1024, 0);

    @(posedge clk); #1;
    check("done_one_cycle", bus.done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gauss_poly_collect.md
Name: gauss_poly_collect

Overview:
- Downstream consumer of the Gaussian sampler. It enables the sampler and collects 2·N signed coefficients: the first N form polynomial f, the next N form polynomial g.
- Writes each coefficient to the external coefficient RAM, checks every coefficient against the keygen range limit, and accumulates the squared norm of (f,g).
- Reports accept/reject so the keygen controller can restart sampling or proceed to the NTRU solve.

Parameters:
- LOGN, 9, log2 of polynomial degree; N = 1<<LOGN. Legal values are 9 and 10.
- VAL_BIT, (LOGN==9)?7:6, width of the incoming signed sample.
- COEF_LIM, (LOGN==9)?32:16, coefficient v is legal iff -COEF_LIM < v < COEF_LIM.
- NORM_BOUND, 16823, (f,g) is rejected iff sqnorm >= NORM_BOUND.
- SQ_W, 24, width of the squared-norm accumulator.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a collection run
- gauss_ena  out  1  enable to the Gaussian sampler
- val_valid  in  1  one-cycle pulse: val holds a finished sample
- val  in  VAL_BIT  signed sample
- coef_we  out  1  RAM write strobe
- coef_sel  out  1  0 = f bank, 1 = g bank
- coef_addr  out  LOGN  coefficient index
- coef_data  out  VAL_BIT  signed coefficient
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at end of run
- reject  out  1  verdict, valid from done and held until next start
- sqnorm  out  SQ_W  final squared norm, held until next start

Behaviour:
- Reset: all outputs are 0. State is IDLE, and the counter, accumulator and flags are cleared. A reset mid-run aborts the run immediately and no done is issued. The RAM contents are then undefined.
- States:
  - IDLE: gauss_ena=0. On start go to RUN_F, clearing idx, sqnorm, reject and range_err.
  - RUN_F: gauss_ena=1. Each val_valid writes coefficient idx to bank 0. When idx==N-1 is accepted, go to RUN_G with idx wrapping to 0.
  - RUN_G: gauss_ena=1. Each val_valid writes to bank 1. When idx==N-1 is accepted, go to CHECK.
  - CHECK: gauss_ena=0. This state lasts exactly one cycle. reject <= range_err | (sqnorm >= NORM_BOUND). Go to DONE.
  - DONE: done=1 for one cycle, then return to IDLE.
- Writes:
  - A write is registered: coef_we, coef_sel, coef_addr and coef_data are asserted the cycle after val_valid.
  - Exactly 2N writes occur per complete run.
- Arithmetic:
  - The square is computed as val*val at 2·VAL_BIT unsigned width and added into SQ_W bits.
  - The accumulator saturates at all-ones and never wraps.
  - range_err is sticky; it is set if any |val| >= COEF_LIM.
- Latency: done asserts 3 cycles after the val_valid carrying the last g coefficient (register, CHECK, DONE).
- Boundaries:
  - val_valid outside RUN_F/RUN_G is ignored, with no write and no count.
  - start while busy is ignored.
  - start in the DONE cycle is ignored; start in the following IDLE cycle is accepted.
  - gauss_ena drops in the CHECK cycle. A late val_valid in CHECK is ignored.
  - val = -2^(VAL_BIT-1) is legal input; its square fits in 2·VAL_BIT bits.

Optional Feature:
- Macro GAUSS_COLLECT_EARLY_ABORT_EN.
- When defined: on the first out-of-range coefficient, the block drops gauss_ena in the next cycle and suppresses the write of that coefficient. It then enters CHECK directly, with reject=1 and sqnorm holding the partial sum. The write count is then less than 2N.
- When undefined: the full run always completes, giving constant timing, and range_err only affects the final verdict.

Decomposition:
- Shared package gauss_pkg holds:
  - the state enum (IDLE, RUN_F, RUN_G, CHECK, DONE);
  - the VAL_BIT and COEF_LIM derivation functions of LOGN;
  - the NORM_BOUND constant.
  - The sampler uses the same derivations.
- One sub-module, gauss_sqacc, holds the signed-square saturating accumulator with a clear input.
- The FSM, counter and write port stay in the top level.

Test Plan:
- LOGN=9, start, then 1024 samples all 0 -> 1024 writes (512 per bank, addresses 0..511 in order), sqnorm=0, reject=0, done 3 cycles after the last val_valid.
- All samples +3 -> sqnorm=9216, reject=0. All samples +4 -> sqnorm=16384, reject=0. 1023 samples 4 and one sample 5 -> sqnorm=16393, reject=0. All samples +5 -> sqnorm=25600, reject=1.
- One sample -32 at f index 7, all others 0 -> reject=1, sqnorm=1024. With EARLY_ABORT_EN: only 7 writes, gauss_ena low the next cycle, done without further writes.
- val_valid pulses while IDLE, plus a start pulse mid-RUN_G -> no extra writes, counts unchanged, run finishes normally.
- rst asserted at g index 100 -> all outputs 0 the next cycle, no done. A new start then gives a full 1024-write run.
- Back-to-back runs: start on the cycle after DONE -> accepted, and reject/sqnorm from the previous run are cleared on that start.
